// File: rtl/cbd_sampler.sv
// Centered-binomial (eta=2) sampler: turns 256-bit PRF chunks into 64 coefficients
// each, reduced into [0, Q-1] and indexed across a 256-coefficient polynomial.
module cbd_sampler #(
  parameter int ETA = 2,
  parameter int Q   = 3329
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_bits,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [11:0]  out_coeff,
  output logic [7:0]   out_index,
  output logic         out_last
);

  localparam int NIB_W = 2 * ETA;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [255:0]   shreg_q, shreg_d;
  logic [5:0]     nib_cnt_q, nib_cnt_d;
  logic [1:0]     chunk_cnt_q, chunk_cnt_d;

  // Map one nibble to (b0+b1)-(b2+b3), folding negatives up by Q.
  function automatic logic [11:0] cbd_coeff(input logic [NIB_W-1:0] nib);
    logic signed [2:0] x;
    logic signed [2:0] y;
    logic signed [2:0] f;
    x = 3'(nib[0]) + 3'(nib[1]);
    y = 3'(nib[2]) + 3'(nib[3]);
    f = x - y;
    if (f < 0)
      cbd_coeff = 12'(Q) + {{9{f[2]}}, f};
    else
      cbd_coeff = {9'b0, f};
  endfunction

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    nib_cnt_d   = nib_cnt_q;
    chunk_cnt_d = chunk_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d   = in_bits;
          nib_cnt_d = '0;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          shreg_d   = shreg_q >> NIB_W;
          nib_cnt_d = nib_cnt_q + 6'd1;
          if (nib_cnt_q == 6'd63) begin
            state_d     = IDLE;
            chunk_cnt_d = chunk_cnt_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      nib_cnt_q   <= '0;
      chunk_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      nib_cnt_q   <= nib_cnt_d;
      chunk_cnt_q <= chunk_cnt_d;
    end
  end

  // Outputs decode registered state only; rst_n gates in_ready so no chunk is taken in reset.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_coeff = cbd_coeff(shreg_q[NIB_W-1:0]);
  assign out_index = {chunk_cnt_q, nib_cnt_q};
  assign out_last  = out_valid && (out_index == 8'd255);

endmodule

// File: tb/tb_cbd_sampler.sv
// Directed bench for cbd_sampler: reset, value mapping, polynomial indexing,
// backpressure and mid-chunk reset.
module tb_cbd_sampler;

  typedef logic [11:0] coeffs_t [64];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] in_bits = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [11:0]  out_coeff;
  logic [7:0]   out_index;
  logic         out_last;

  int tests = 0;
  int fails = 0;

  cbd_sampler #(.ETA(2), .Q(3329)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coeff (out_coeff),
    .out_index (out_index),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rep_byte(input logic [7:0] b);
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[8*i +: 8] = b;
    return v;
  endfunction

  function automatic coeffs_t model(input logic [255:0] bits);
    coeffs_t c;
    for (int i = 0; i < 64; i++) begin
      int x;
      int y;
      x = int'(bits[4*i]) + int'(bits[4*i+1]);
      y = int'(bits[4*i+2]) + int'(bits[4*i+3]);
      c[i] = 12'((x - y + 3329) % 3329);
    end
    return c;
  endfunction

  function automatic logic [255:0] rand_bits();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Called at a negedge in IDLE; returns just after the accepting edge.
  task automatic send_chunk(input logic [255:0] bits);
    in_valid = 1'b1;
    in_bits  = bits;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bits  = '0;
  endtask

  task automatic expect_coeff(input int base, input int k, input logic [11:0] c);
    check($sformatf("valid[%0d]", base + k), 32'(out_valid), 32'd1);
    check($sformatf("ready_emit[%0d]", base + k), 32'(in_ready), 32'd0);
    check($sformatf("coeff[%0d]", base + k), 32'(out_coeff), 32'(c));
    check($sformatf("index[%0d]", base + k), 32'(out_index), 32'(base + k));
    check($sformatf("last[%0d]", base + k), 32'(out_last), 32'((base + k) == 255));
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic expect_chunk(input string tag, input coeffs_t exp, input int base);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      expect_coeff(base, k, exp[k]);
    end
    expect_idle(tag);
  endtask

  initial begin
    coeffs_t      exp;
    logic [255:0] bits;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_coeff", 32'(out_coeff), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // 0x31: nibble 1 -> 1, nibble 3 -> 2.
    for (int i = 0; i < 64; i++) exp[i] = (i % 2 == 0) ? 12'd1 : 12'd2;
    send_chunk(rep_byte(8'h31));
    expect_chunk("c31", exp, 0);

    // 0xC4: nibble 4 -> -1 -> 3328, nibble C -> -2 -> 3327.
    for (int i = 0; i < 64; i++) exp[i] = (i % 2 == 0) ? 12'd3328 : 12'd3327;
    send_chunk(rep_byte(8'hC4));
    expect_chunk("cC4", exp, 64);

    for (int i = 0; i < 64; i++) exp[i] = 12'd0;
    send_chunk(rep_byte(8'hFF));
    expect_chunk("cFF", exp, 128);
    send_chunk(rep_byte(8'h00));
    expect_chunk("c00", exp, 192);

    // Full random polynomial, chunks back to back.
    for (int c = 0; c < 4; c++) begin
      bits = rand_bits();
      exp  = model(bits);
      send_chunk(bits);
      expect_chunk($sformatf("poly%0d", c), exp, 64 * c);
    end

    // Fifth chunk restarts at index 0; stall 5 cycles at index 10.
    bits = rand_bits();
    exp  = model(bits);
    send_chunk(bits);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      expect_coeff(0, k, exp[k]);
      if (k == 10) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check($sformatf("bp_valid%0d", s), 32'(out_valid), 32'd1);
          check($sformatf("bp_coeff%0d", s), 32'(out_coeff), 32'(exp[10]));
          check($sformatf("bp_index%0d", s), 32'(out_index), 32'd10);
        end
        out_ready = 1'b1;
      end
    end
    expect_idle("bp");

    // Reset for one edge while showing index 70.
    bits = rand_bits();
    exp  = model(bits);
    send_chunk(bits);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      expect_coeff(64, k, exp[k]);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_index", 32'(out_index), 32'd0);
    check("mid_rst_coeff", 32'(out_coeff), 32'd0);

    bits = rand_bits();
    exp  = model(bits);
    send_chunk(bits);
    expect_chunk("after_rst", exp, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
